// File: rtl/instr_sequencer_pkg.sv
// Shared ISA encoding, instruction field positions, default widths, sequencer state and
// the decoded control bundle for instr_sequencer.
package instr_sequencer_pkg;

  localparam int DEF_IP_BITS       = 8;
  localparam int DEF_MEM_DATA_BITS = 8;
  localparam int DEF_INSTR_BITS    = 16;
  localparam int DEF_REG_ADDR_BITS = 4;
  localparam int DEF_REG_DATA_BITS = 8;

  // Field positions inside the 16-bit instruction core
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MOVIR = 4'h1,
    OP_MOVRR = 4'h2,
    OP_ADDRR = 4'h3,
    OP_SUBRR = 4'h4,
    OP_ADDI  = 4'h5,
    OP_SUBI  = 4'h6,
    OP_JZI   = 4'h7,
    OP_JZR   = 4'h8,
    OP_MOVMR = 4'h9,
    OP_MOVRM = 4'hA
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXECUTE,
    S_TRAP
  } seq_state_t;

  typedef struct packed {
    logic       rd0_en;
    logic       rd1_en;
    logic       wr_en;
    logic [3:0] rd0_addr;
    logic [3:0] rd1_addr;
    logic [3:0] wr_addr;
    logic [7:0] imm;
    logic       alu_a_sel;
    logic       reg_in_sel;
    logic       subtract;
    logic       jzi;
    logic       jzr;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/instr_sequencer_decoder.sv
// Combinational opcode decoder: 16-bit instruction core -> control bundle.
module instr_sequencer_decoder
  import instr_sequencer_pkg::*;
(
  input  logic [15:0] instr_i,
  output ctrl_t       ctrl_o
);

  opcode_t    op;
  logic [3:0] rd, rs1, rs2;
  logic [7:0] imm8;

  assign op   = opcode_t'(instr_i[OP_MSB:OP_LSB]);
  assign rd   = instr_i[RD_MSB:RD_LSB];
  assign rs1  = instr_i[RS1_MSB:RS1_LSB];
  assign rs2  = instr_i[RS2_MSB:RS2_LSB];
  assign imm8 = instr_i[IMM_MSB:IMM_LSB];

  always_comb begin
    ctrl_o = '0;
    case (op)
      OP_NOP: ;
      OP_MOVIR: begin
        ctrl_o.wr_en      = 1'b1;
        ctrl_o.wr_addr    = rd;
        ctrl_o.imm        = imm8;
        ctrl_o.reg_in_sel = 1'b1;
      end
      OP_MOVRR: begin
        // b port left disabled so the ALU passes a + 0
        ctrl_o.rd0_en   = 1'b1;
        ctrl_o.rd0_addr = rs1;
        ctrl_o.wr_en    = 1'b1;
        ctrl_o.wr_addr  = rd;
      end
      OP_ADDRR, OP_SUBRR: begin
        ctrl_o.rd0_en   = 1'b1;
        ctrl_o.rd0_addr = rs1;
        ctrl_o.rd1_en   = 1'b1;
        ctrl_o.rd1_addr = rs2;
        ctrl_o.wr_en    = 1'b1;
        ctrl_o.wr_addr  = rd;
        ctrl_o.subtract = (op == OP_SUBRR);
      end
      OP_ADDI, OP_SUBI: begin
        ctrl_o.alu_a_sel = 1'b1;
        ctrl_o.imm       = imm8;
        ctrl_o.rd1_en    = 1'b1;
        ctrl_o.rd1_addr  = rd;
        ctrl_o.wr_en     = 1'b1;
        ctrl_o.wr_addr   = rd;
        ctrl_o.subtract  = (op == OP_SUBI);
      end
      OP_JZI: begin
        ctrl_o.imm = imm8;
        ctrl_o.jzi = 1'b1;
      end
      OP_JZR: begin
        ctrl_o.rd0_en   = 1'b1;
        ctrl_o.rd0_addr = rd;
        ctrl_o.jzr      = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;  // MOVMR, MOVRM and unassigned codes
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer over a variable-latency read port.
// Define INSTR_SEQUENCER_ILLEGAL_TRAP_EN to halt in TRAP on an illegal opcode.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int                 IP_BITS       = DEF_IP_BITS,
  parameter int                 MEM_DATA_BITS = DEF_MEM_DATA_BITS,
  parameter int                 INSTR_BITS    = DEF_INSTR_BITS,
  parameter int                 REG_ADDR_BITS = DEF_REG_ADDR_BITS,
  parameter int                 REG_DATA_BITS = DEF_REG_DATA_BITS,
  parameter logic [IP_BITS-1:0] RESET_VECTOR  = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [IP_BITS-1:0]       mem_addr,
  output logic                     mem_rd_en,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_data,
  input  logic                     mem_rd_valid,
  input  logic                     zero_flag,
  input  logic [REG_DATA_BITS-1:0] reg_rd0_data,
  output logic                     reg_rd0_en,
  output logic                     reg_rd1_en,
  output logic                     reg_wr_en,
  output logic [REG_ADDR_BITS-1:0] reg_rd0_addr,
  output logic [REG_ADDR_BITS-1:0] reg_rd1_addr,
  output logic [REG_ADDR_BITS-1:0] reg_wr_addr,
  output logic [REG_DATA_BITS-1:0] imm,
  output logic                     alu_a_sel,
  output logic                     reg_in_sel,
  output logic                     subtract,
  output logic                     illegal_op,
  output logic [IP_BITS-1:0]       ip
);

  localparam int WORDS = INSTR_BITS / MEM_DATA_BITS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (INSTR_BITS % MEM_DATA_BITS != 0) begin : g_bad_ratio
    $error("INSTR_BITS must be an integer multiple of MEM_DATA_BITS");
  end
  if (INSTR_BITS < 16) begin : g_bad_width
    $error("INSTR_BITS must be at least 16");
  end

  seq_state_t              state_q, state_d;
  logic [IP_BITS-1:0]      ip_q, ip_d;
  logic [INSTR_BITS-1:0]   ir_q, ir_d, ir_shift;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  ctrl_t                   ctrl_q, ctrl_d, dec;
  logic                    last_word;

  // Most significant word arrives first; decode sees the fully assembled word.
  assign ir_shift  = (ir_q << MEM_DATA_BITS) | INSTR_BITS'(mem_rd_data);
  assign last_word = (cnt_q == CNT_W'(WORDS - 1));

  instr_sequencer_decoder u_dec (
    .instr_i (ir_shift[INSTR_BITS-1 -: 16]),
    .ctrl_o  (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ip_q    <= RESET_VECTOR;
      ir_q    <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rd_valid) begin
          ir_d = ir_shift;
          ip_d = ip_q + IP_BITS'(1);
          if (last_word) begin
            cnt_d   = '0;
            ctrl_d  = dec;
            state_d = S_DECODE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_FETCH;
        // ip already points past the instruction, so JZI is relative to the next one
        if (zero_flag && ctrl_q.jzi) ip_d = ip_q + IP_BITS'($signed(ctrl_q.imm));
        else if (zero_flag && ctrl_q.jzr) ip_d = IP_BITS'(reg_rd0_data);
`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
        if (ctrl_q.illegal) state_d = S_TRAP;
`endif
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is asserted so nothing leaks out of the reset cycle.
  always_comb begin
    mem_addr     = ip_q;
    ip           = ip_q;
    mem_rd_en    = (state_q == S_FETCH) && !reset;
    reg_wr_en    = (state_q == S_EXECUTE) && ctrl_q.wr_en && !reset;
    illegal_op   = (((state_q == S_EXECUTE) && ctrl_q.illegal) || (state_q == S_TRAP)) && !reset;
    reg_rd0_en   = ctrl_q.rd0_en;
    reg_rd1_en   = ctrl_q.rd1_en;
    reg_rd0_addr = REG_ADDR_BITS'(ctrl_q.rd0_addr);
    reg_rd1_addr = REG_ADDR_BITS'(ctrl_q.rd1_addr);
    reg_wr_addr  = REG_ADDR_BITS'(ctrl_q.wr_addr);
    imm          = REG_DATA_BITS'(ctrl_q.imm);
    alu_a_sel    = ctrl_q.alu_a_sel;
    reg_in_sel   = ctrl_q.reg_in_sel;
    subtract     = ctrl_q.subtract;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: default-width instance plus a 4-bit ip/4-bit memory instance.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       reset, zero_flag;
  logic [7:0] mem_addr, mem_rd_data, reg_rd0_data, imm, ip;
  logic       mem_rd_en, mem_rd_valid;
  logic       reg_rd0_en, reg_rd1_en, reg_wr_en, alu_a_sel, reg_in_sel, subtract, illegal_op;
  logic [3:0] reg_rd0_addr, reg_rd1_addr, reg_wr_addr;

  instr_sequencer u_dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .zero_flag(zero_flag),
    .reg_rd0_data(reg_rd0_data), .reg_rd0_en(reg_rd0_en), .reg_rd1_en(reg_rd1_en),
    .reg_wr_en(reg_wr_en), .reg_rd0_addr(reg_rd0_addr), .reg_rd1_addr(reg_rd1_addr),
    .reg_wr_addr(reg_wr_addr), .imm(imm), .alu_a_sel(alu_a_sel), .reg_in_sel(reg_in_sel),
    .subtract(subtract), .illegal_op(illegal_op), .ip(ip)
  );

  // 4-bit ip / 4-bit memory instance starting at address F
  logic       r4;
  logic [3:0] a4, d4, ip4, ra4, rb4, rw4;
  logic [7:0] imm4;
  logic       rd4, v4, e0_4, e1_4, we4, as4, rs4, sb4, il4;

  instr_sequencer #(.IP_BITS(4), .MEM_DATA_BITS(4), .RESET_VECTOR(4'hF)) u_w4 (
    .clk(clk), .reset(r4), .mem_addr(a4), .mem_rd_en(rd4), .mem_rd_data(d4),
    .mem_rd_valid(v4), .zero_flag(1'b0), .reg_rd0_data(8'h00), .reg_rd0_en(e0_4),
    .reg_rd1_en(e1_4), .reg_wr_en(we4), .reg_rd0_addr(ra4), .reg_rd1_addr(rb4),
    .reg_wr_addr(rw4), .imm(imm4), .alu_a_sel(as4), .reg_in_sel(rs4), .subtract(sb4),
    .illegal_op(il4), .ip(ip4)
  );

  // memory model: valid arrives lat cycles after the rd_en cycle
  logic [7:0] mem [256];
  int         lat = 1;
  int         cnt = 0;
  bit         pend = 1'b0;
  logic [7:0] paddr = '0;

  always @(posedge clk) begin
    mem_rd_valid <= 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= mem[paddr];
        pend         <= 1'b0;
      end else cnt <= cnt - 1;
    end
    if (mem_rd_en) begin
      if (lat <= 1) begin
        mem_rd_valid <= 1'b1;
        mem_rd_data  <= mem[mem_addr];
      end else begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= mem_addr;
      end
    end
  end

  logic [3:0] mem4 [16];
  always @(posedge clk) begin
    v4 <= 1'b0;
    if (rd4) begin
      v4 <= 1'b1;
      d4 <= mem4[a4];
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int nrd, wcyc;
    reset = 1'b1; r4 = 1'b1; zero_flag = 1'b0; reg_rd0_data = 8'h00;
    mem_rd_valid = 1'b0; mem_rd_data = '0; v4 = 1'b0; d4 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem4[i] = 4'h0;
    mem[0] = {OP_MOVIR, 4'h3}; mem[1] = 8'h5A;   // MOVIR r3 #5A
    mem[2] = {OP_SUBRR, 4'h1}; mem[3] = 8'h23;   // SUBRR r1 r2 r3
    mem[4] = {OP_JZI,   4'h0}; mem[5] = 8'hFE;   // JZI #FE
    mem[6] = {OP_MOVRM, 4'h0}; mem[7] = 8'h00;   // MOVRM (illegal)

    tick(2);
    chk("rst_ip", ip, 8'h00);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_wr_en", reg_wr_en, 1'b0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_imm", imm, 8'h00);

    // MOVIR: cycle 1 FETCH ... cycle 5 DECODE, cycle 6 EXECUTE
    reset = 1'b0; #1;
    chk("movir_fetch_en", mem_rd_en, 1'b1);
    chk("movir_fetch_addr", mem_addr, 8'h00);
    tick(4);
    chk("movir_wr_addr", reg_wr_addr, 4'h3);
    chk("movir_imm", imm, 8'h5A);
    chk("movir_in_sel", reg_in_sel, 1'b1);
    chk("movir_no_early_wr", reg_wr_en, 1'b0);
    tick(1);
    chk("movir_wr_en", reg_wr_en, 1'b1);
    chk("movir_ip", ip, 8'h02);
    tick(1);
    chk("movir_wr_pulse_end", reg_wr_en, 1'b0);
    chk("subrr_fetch_addr", mem_addr, 8'h02);

    // SUBRR r1 r2 r3
    tick(4);
    chk("subrr_rd0_addr", reg_rd0_addr, 4'h2);
    chk("subrr_rd1_addr", reg_rd1_addr, 4'h3);
    chk("subrr_subtract", subtract, 1'b1);
    chk("subrr_wr_addr", reg_wr_addr, 4'h1);
    chk("subrr_a_sel", alu_a_sel, 1'b0);
    tick(1);
    chk("subrr_wr_en", reg_wr_en, 1'b1);
    zero_flag = 1'b1;

    // JZI #FE taken: self loop back to 4
    tick(5);
    chk("jzi_imm", imm, 8'hFE);
    tick(1);
    chk("jzi_exec_ip", ip, 8'h06);
    tick(1);
    chk("jzi_taken_ip", ip, 8'h04);
    chk("jzi_taken_addr", mem_addr, 8'h04);
    zero_flag = 1'b0;
    tick(6);
    chk("jzi_not_taken_ip", ip, 8'h06);

    // MOVRM: illegal
    tick(5);
    chk("movrm_illegal", illegal_op, 1'b1);
    chk("movrm_no_wr", reg_wr_en, 1'b0);
    tick(1);
`ifdef INSTR_SEQUENCER_ILLEGAL_TRAP_EN
    chk("trap_illegal_held", illegal_op, 1'b1);
    chk("trap_no_fetch", mem_rd_en, 1'b0);
    tick(4);
    chk("trap_illegal_later", illegal_op, 1'b1);
    chk("trap_no_fetch_later", mem_rd_en, 1'b0);
    chk("trap_ip_frozen", ip, 8'h08);
`else
    chk("illegal_pulse_end", illegal_op, 1'b0);
    chk("illegal_continue_en", mem_rd_en, 1'b1);
    chk("illegal_continue_addr", mem_addr, 8'h08);
`endif

    // 3-cycle memory: 10 cycles per instruction, two fetches
    reset = 1'b1; tick(1);
    reset = 1'b0; lat = 3; #1;
    nrd = 0; wcyc = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick(1);
      if (mem_rd_en) nrd++;
      if (reg_wr_en && wcyc == 0) wcyc = c;
    end
    chk("slow_rd_pulses", nrd, 2);
    chk("slow_wr_cycle", wcyc, 10);
    chk("slow_imm", imm, 8'h5A);
    chk("slow_wr_addr", reg_wr_addr, 4'h3);
    chk("slow_ip", ip, 8'h02);

    // reset during WAIT; the completion lands after reset and must be dropped
    reset = 1'b1; tick(1);
    reset = 1'b0; lat = 2; #1;
    tick(1);
    reset = 1'b1; tick(1);
    reset = 1'b0; lat = 1; #1;
    chk("stale_ip", ip, 8'h00);
    chk("stale_addr", mem_addr, 8'h00);
    chk("stale_refetch", mem_rd_en, 1'b1);
    tick(5);
    chk("stale_wr_en", reg_wr_en, 1'b1);
    chk("stale_ip_after", ip, 8'h02);

    // JZR to 3C, then ADDI r7 #10 there
    reset = 1'b1;
    mem[0] = {OP_JZR, 4'h5};  mem[1] = 8'h00;
    mem[8'h3C] = {OP_ADDI, 4'h7}; mem[8'h3D] = 8'h10;
    reg_rd0_data = 8'h3C; zero_flag = 1'b1;
    tick(1);
    reset = 1'b0; #1;
    tick(4);
    chk("jzr_rd0_en", reg_rd0_en, 1'b1);
    chk("jzr_rd0_addr", reg_rd0_addr, 4'h5);
    tick(2);
    chk("jzr_ip", ip, 8'h3C);
    zero_flag = 1'b0;
    tick(4);
    chk("addi_rd1_en", reg_rd1_en, 1'b1);
    chk("addi_rd1_addr", reg_rd1_addr, 4'h7);
    chk("addi_a_sel", alu_a_sel, 1'b1);
    chk("addi_imm", imm, 8'h10);
    chk("addi_sub", subtract, 1'b0);
    tick(1);
    chk("addi_wr_en", reg_wr_en, 1'b1);
    chk("addi_ip", ip, 8'h3E);

    // 4-word NOP at F wraps through 0 to 3
    r4 = 1'b0; #1;
    chk("w4_first_addr", a4, 4'hF);
    chk("w4_first_en", rd4, 1'b1);
    tick(2);
    chk("w4_wrap_addr", a4, 4'h0);
    tick(7);
    chk("w4_exec_ip", ip4, 4'h3);
    chk("w4_no_illegal", il4, 1'b0);
    tick(1);
    chk("w4_next_addr", a4, 4'h3);
    chk("w4_next_en", rd4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
